// File: rtl/bridge_pkg.sv
// Shared types and fixed AXI field values for the SRAM-to-AXI bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bridge_pkg;

    typedef enum logic [3:0] {
        IDLE,
        D_RD_A,
        D_RD_R,
        D_WR,
        D_B,
        D_DONE,
        I_RD_A,
        I_RD_R,
        I_DONE
    } state_t;

    localparam int         ID_INST    = 0;
    localparam int         ID_DATA    = 1;
    localparam logic [2:0] SIZE_WORD  = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;

endpackage

// File: rtl/sram_axi_bridge_if.sv
// Single AXI3 master port (read + write channels) shared by fetch and data traffic.
// Latency: n/a (wires only).
// Backpressure: standard AXI valid/ready on every channel.
interface sram_axi_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [3:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;
    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [3:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;
    logic [ID_W-1:0]     wid;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wid, wdata, wstrb, wlast, wvalid, bready,
        input  arready, rid, rdata, rresp, rlast, rvalid,
        input  awready, wready, bid, bresp, bvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wid, wdata, wstrb, wlast, wvalid, bready,
        output arready, rid, rdata, rresp, rlast, rvalid,
        output awready, wready, bid, bresp, bvalid
    );

endinterface

// File: rtl/bridge_ibuf.sv
// One-entry fetch buffer: tag + data of the last fetched word, combinational lookup.
// Latency: hit visible in the same cycle; fill/invalidate take effect next cycle.
// Backpressure: none; invalidate wins over a same-cycle fill.
module bridge_ibuf #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              fill,
    input  logic [ADDR_W-1:0] fill_tag,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              inval,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [DATA_W-1:0] hit_data
);

    logic              valid_q;
    logic [ADDR_W-1:0] tag_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else if (inval) begin
            valid_q <= 1'b0;
        end else if (fill) begin
            valid_q <= 1'b1;
            tag_q   <= fill_tag;
            data_q  <= fill_data;
        end
    end

    assign hit      = valid_q && (tag_q == lookup_addr);
    assign hit_data = data_q;

endmodule

// File: rtl/sram_axi_bridge.sv
// CPU inst/data SRAM ports -> single-beat AXI3 master, one transaction at a time, data first.
// Latency: done 3 cycles after request sampled with zero-wait slave (1 cycle on a fetch-buffer hit).
// Backpressure: each AXI wait cycle adds one cycle; cpu_stall held until done. Option: SRAM_AXI_BRIDGE_IBUF_EN.
module sram_axi_bridge
    import bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic [DATA_W-1:0]   inst_rdata,
    output logic                inst_done,
    input  logic                data_req,
    input  logic [DATA_W/8-1:0] data_wen,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                data_done,
    output logic                cpu_stall,
    sram_axi_bridge_if.master   axi
);

    state_t                state_q, state_d;
    logic                  aw_ok_q, w_ok_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W/8-1:0]   wstrb_q;
    logic [DATA_W-1:0]     inst_rdata_q, data_rdata_q;
    logic                  ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic                  ibuf_hit;
    logic [DATA_W-1:0]     ibuf_data;
    logic                  unused_resp;

    assign ar_hs = axi.arvalid & axi.arready;
    assign r_hs  = axi.rvalid  & axi.rready;
    assign aw_hs = axi.awvalid & axi.awready;
    assign w_hs  = axi.wvalid  & axi.wready;
    assign b_hs  = axi.bvalid  & axi.bready;

`ifdef SRAM_AXI_BRIDGE_IBUF_EN
    bridge_ibuf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ibuf (
        .clk         (clk),
        .resetn      (resetn),
        .fill        (state_q == I_RD_R && r_hs),
        .fill_tag    (addr_q),
        .fill_data   (axi.rdata),
        .inval       (state_q == D_B && b_hs),
        .lookup_addr (inst_addr),
        .hit         (ibuf_hit),
        .hit_data    (ibuf_data)
    );
`else
    assign ibuf_hit  = 1'b0;
    assign ibuf_data = '0;
`endif

    always_comb begin
        state_d     = state_q;
        axi.arvalid = 1'b0;
        axi.rready  = 1'b0;
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        axi.bready  = 1'b0;
        inst_done   = 1'b0;
        data_done   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (data_req)
                    state_d = (data_wen == '0) ? D_RD_A : D_WR;
                else if (inst_req)
                    state_d = ibuf_hit ? I_DONE : I_RD_A;
            end
            D_RD_A, I_RD_A: begin
                axi.arvalid = 1'b1;
                if (ar_hs) state_d = (state_q == D_RD_A) ? D_RD_R : I_RD_R;
            end
            D_RD_R, I_RD_R: begin
                axi.rready = 1'b1;
                if (r_hs) state_d = (state_q == D_RD_R) ? D_DONE : I_DONE;
            end
            D_WR: begin
                // each side drops its valid once its own handshake has been seen
                axi.awvalid = ~aw_ok_q;
                axi.wvalid  = ~w_ok_q;
                if ((aw_ok_q | aw_hs) && (w_ok_q | w_hs)) state_d = D_B;
            end
            D_B: begin
                axi.bready = 1'b1;
                if (b_hs) state_d = D_DONE;
            end
            D_DONE: begin
                data_done = 1'b1;
                state_d   = IDLE;
            end
            I_DONE: begin
                inst_done = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            aw_ok_q      <= 1'b0;
            w_ok_q       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                addr_q  <= data_req ? data_addr : inst_addr;
                wdata_q <= data_wdata;
                wstrb_q <= data_wen;
            end
            if (state_q == D_WR) begin
                aw_ok_q <= aw_ok_q | aw_hs;
                w_ok_q  <= w_ok_q  | w_hs;
            end else begin
                aw_ok_q <= 1'b0;
                w_ok_q  <= 1'b0;
            end
            if (state_q == D_RD_R && r_hs)
                data_rdata_q <= axi.rdata;
            if (state_q == I_RD_R && r_hs)
                inst_rdata_q <= axi.rdata;
            if (state_q == IDLE && !data_req && inst_req && ibuf_hit)
                inst_rdata_q <= ibuf_data;
        end
    end

    assign inst_rdata  = inst_rdata_q;
    assign data_rdata  = data_rdata_q;
    assign cpu_stall   = (inst_req & ~inst_done) | (data_req & ~data_done);

    assign axi.arid    = (state_q == I_RD_A) ? ID_W'(ID_INST) : ID_W'(ID_DATA);
    assign axi.araddr  = addr_q;
    assign axi.arlen   = 4'd0;
    assign axi.arsize  = SIZE_WORD;
    assign axi.arburst = BURST_INCR;
    assign axi.awid    = ID_W'(ID_DATA);
    assign axi.awaddr  = addr_q;
    assign axi.awlen   = 4'd0;
    assign axi.awsize  = SIZE_WORD;
    assign axi.awburst = BURST_INCR;
    assign axi.wid     = ID_W'(ID_DATA);
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wlast   = 1'b1;

    // responses and ids are never checked: only one transaction is ever outstanding
    assign unused_resp = ^{axi.rid, axi.rresp, axi.rlast, axi.bid, axi.bresp};

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Bench for sram_axi_bridge: table of single transactions against a wait-state-configurable
// AXI slave, plus hand sequences for contention, stalls, mid-read reset and the fetch buffer.
module tb_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_req = 1'b0, data_req = 1'b0;
    logic [31:0] inst_addr = '0, data_addr = '0, data_wdata = '0;
    logic [3:0]  data_wen = '0;
    logic [31:0] inst_rdata, data_rdata;
    logic        inst_done, data_done, cpu_stall;

    always #5 clk = ~clk;

    sram_axi_bridge_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) axi ();

    sram_axi_bridge #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .inst_req   (inst_req),
        .inst_addr  (inst_addr),
        .inst_rdata (inst_rdata),
        .inst_done  (inst_done),
        .data_req   (data_req),
        .data_wen   (data_wen),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_rdata (data_rdata),
        .data_done  (data_done),
        .cpu_stall  (cpu_stall),
        .axi        (axi)
    );

    // ---------------- AXI slave model ----------------
    int          ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
    logic [31:0] rd_word_d = '0, rd_word_i = '0;
    int          ar_c, r_c, aw_c, w_c, b_c;
    logic        r_pend, b_pend, aw_got, w_got;
    logic [3:0]  r_id;
    logic [31:0] cap_awaddr, cap_wdata;
    logic [3:0]  cap_awid, cap_wid, cap_wstrb, cap_awlen, cap_arlen;
    logic [2:0]  cap_awsize, cap_arsize;
    logic [1:0]  cap_awburst, cap_arburst;
    logic        cap_wlast;
    int          cyc = 0;
    int          ar_n = 0, av_cyc = 0;
    logic [3:0]  ar_hist_id   [64];
    logic [31:0] ar_hist_addr [64];
    int          ar_hist_cyc  [64];

    assign axi.arready = axi.arvalid && (ar_c >= ar_wait);
    assign axi.awready = axi.awvalid && (aw_c >= aw_wait);
    assign axi.wready  = axi.wvalid  && (w_c  >= w_wait);
    assign axi.rvalid  = r_pend && (r_c >= r_wait);
    assign axi.rdata   = (r_id == 4'd0) ? rd_word_i : rd_word_d;
    assign axi.rid     = r_id;
    assign axi.rresp   = 2'b00;
    assign axi.rlast   = 1'b1;
    assign axi.bvalid  = b_pend && (b_c >= b_wait);
    assign axi.bid     = 4'd1;
    assign axi.bresp   = 2'b00;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ar_c <= 0; r_c <= 0; aw_c <= 0; w_c <= 0; b_c <= 0;
            r_pend <= 1'b0; b_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; r_id <= '0;
        end else begin
            ar_c <= (axi.arvalid && !axi.arready) ? ar_c + 1 : 0;
            aw_c <= (axi.awvalid && !axi.awready) ? aw_c + 1 : 0;
            w_c  <= (axi.wvalid  && !axi.wready)  ? w_c + 1  : 0;
            r_c  <= r_pend ? r_c + 1 : 0;
            b_c  <= b_pend ? b_c + 1 : 0;
            if (axi.arvalid && axi.arready) begin
                r_pend <= 1'b1; r_id <= axi.arid;
                cap_arlen <= axi.arlen; cap_arsize <= axi.arsize; cap_arburst <= axi.arburst;
            end
            if (axi.rvalid && axi.rready) r_pend <= 1'b0;
            if (axi.awvalid && axi.awready) begin
                aw_got <= 1'b1; cap_awaddr <= axi.awaddr; cap_awid <= axi.awid;
                cap_awlen <= axi.awlen; cap_awsize <= axi.awsize; cap_awburst <= axi.awburst;
            end
            if (axi.wvalid && axi.wready) begin
                w_got <= 1'b1; cap_wdata <= axi.wdata; cap_wstrb <= axi.wstrb;
                cap_wid <= axi.wid; cap_wlast <= axi.wlast;
            end
            if (!b_pend && (aw_got || (axi.awvalid && axi.awready)) && (w_got || (axi.wvalid && axi.wready))) begin
                b_pend <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
            end
            if (axi.bvalid && axi.bready) b_pend <= 1'b0;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (resetn && axi.arvalid) av_cyc <= av_cyc + 1;
        if (resetn && axi.arvalid && axi.arready) begin
            ar_hist_id[ar_n % 64]   <= axi.arid;
            ar_hist_addr[ar_n % 64] <= axi.araddr;
            ar_hist_cyc[ar_n % 64]  <= cyc;
            ar_n <= ar_n + 1;
        end
    end

    // valid must not drop and payload must not move before its handshake
    logic        p_arv, p_arhs, p_awv, p_awhs, p_wv, p_whs;
    logic [31:0] p_araddr, p_awaddr, p_wdata;
    logic [3:0]  p_arid, p_wstrb;
    int          stab_viol = 0;
    always @(negedge clk) begin
        if (!resetn) begin
            p_arv <= 1'b0; p_awv <= 1'b0; p_wv <= 1'b0;
        end else begin
            if (p_arv && !p_arhs && (!axi.arvalid || axi.araddr !== p_araddr || axi.arid !== p_arid))
                stab_viol <= stab_viol + 1;
            if (p_awv && !p_awhs && (!axi.awvalid || axi.awaddr !== p_awaddr))
                stab_viol <= stab_viol + 1;
            if (p_wv && !p_whs && (!axi.wvalid || axi.wdata !== p_wdata || axi.wstrb !== p_wstrb))
                stab_viol <= stab_viol + 1;
            p_arv <= axi.arvalid; p_arhs <= axi.arvalid && axi.arready;
            p_araddr <= axi.araddr; p_arid <= axi.arid;
            p_awv <= axi.awvalid; p_awhs <= axi.awvalid && axi.awready; p_awaddr <= axi.awaddr;
            p_wv <= axi.wvalid; p_whs <= axi.wvalid && axi.wready;
            p_wdata <= axi.wdata; p_wstrb <= axi.wstrb;
        end
    end

    // ---------------- scoreboard and helpers ----------------
    typedef struct {
        bit          is_data;
        logic [31:0] rdata;
        bit          chk_rd;
        int          lat;
        int          t0;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        bit          is_data;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rword;
        int          ar_w, r_w, aw_w, w_w, b_w;
        int          exp_lat;
    } vec_t;
    vec_t vt[7];

    int checks = 0, errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic issue(input bit is_data, input logic [3:0] wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd, input int lat);
        exp_t e;
        e.is_data = is_data;
        e.rdata   = exp_rd;
        e.chk_rd  = !is_data || (wen == 4'd0);
        e.lat     = lat;
        e.t0      = cyc;
        if (is_data) begin
            data_req = 1'b1; data_wen = wen; data_addr = addr; data_wdata = wdata;
        end else begin
            inst_req = 1'b1; inst_addr = addr;
        end
        sbq.push_back(e);
    endtask

    // runs until every queued transaction completed, plus a short tail to catch extra done pulses
    task automatic run_until_empty(input int budget);
        int   n = 0, tail = 0;
        bit   dd = 0, di = 0;
        exp_t e;
        while (tail < 3 && n < budget) begin
            @(negedge clk);
            if (inst_done || data_done) begin
                if (sbq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_done: got inst_done=%0b data_done=%0b, expected no pulse", inst_done, data_done);
                end else begin
                    e = sbq.pop_front();
                    check("done_kind", {31'd0, data_done}, {31'd0, e.is_data});
                    if (e.chk_rd) check("rdata", data_done ? data_rdata : inst_rdata, e.rdata);
                    check("latency", cyc - e.t0, e.lat);
                end
                dd = data_done; di = inst_done;
            end
            @(posedge clk); #1; n++;
            if (dd) begin data_req = 1'b0; dd = 0; end
            if (di) begin inst_req = 1'b0; di = 0; end
            if (sbq.size() == 0 && !data_req && !inst_req) tail++; else tail = 0;
        end
        check("completed_in_budget", {31'd0, n < budget}, 32'd1);
        if (n >= budget) begin
            sbq.delete(); data_req = 1'b0; inst_req = 1'b0;
        end
    endtask

    initial begin
        int ar0, av0, t0;

        vt[0] = '{1, 4'h0,    32'h1FC0_0010, 32'h0,          32'hDEAD_BEEF, 0, 0, 0, 0, 0, 3};
        vt[1] = '{1, 4'b0100, 32'h0000_1000, 32'h00AB_0000,  32'h0,         0, 0, 3, 0, 0, 6};
        vt[2] = '{0, 4'h0,    32'hBFC0_0000, 32'h0,          32'h3C08_0001, 5, 0, 0, 0, 0, 8};
        vt[3] = '{1, 4'h0,    32'h8000_0004, 32'h0,          32'h1234_5678, 0, 2, 0, 0, 0, 5};
        vt[4] = '{1, 4'hF,    32'h8000_0008, 32'hCAFE_F00D,  32'h0,         0, 0, 0, 2, 1, 6};
        vt[5] = '{0, 4'h0,    32'h0000_0040, 32'h0,          32'h0000_0013, 0, 0, 0, 0, 0, 3};
        vt[6] = '{0, 4'h0,    32'h0000_0044, 32'h0,          32'h2402_0005, 1, 1, 0, 0, 0, 5};

        // reset state
        #12;
        check("rst_arvalid", {31'd0, axi.arvalid}, 0);
        check("rst_rready",  {31'd0, axi.rready},  0);
        check("rst_awvalid", {31'd0, axi.awvalid}, 0);
        check("rst_wvalid",  {31'd0, axi.wvalid},  0);
        check("rst_bready",  {31'd0, axi.bready},  0);
        check("rst_done",    {30'd0, inst_done, data_done}, 0);
        check("rst_rdata",   inst_rdata | data_rdata, 0);
        @(negedge clk) resetn = 1'b1;
        @(posedge clk); #1;

        // table-driven single transactions
        for (int i = 0; i < 7; i++) begin
            ar_wait = vt[i].ar_w; r_wait = vt[i].r_w;
            aw_wait = vt[i].aw_w; w_wait = vt[i].w_w; b_wait = vt[i].b_w;
            rd_word_d = vt[i].rword; rd_word_i = vt[i].rword;
            ar0 = ar_n;
            issue(vt[i].is_data, vt[i].wen, vt[i].addr, vt[i].wdata, vt[i].rword, vt[i].exp_lat);
            run_until_empty(100);
            if (vt[i].is_data && vt[i].wen != 4'd0) begin
                check("st_no_ar",   ar_n - ar0, 0);
                check("st_awaddr",  cap_awaddr, vt[i].addr);
                check("st_wdata",   cap_wdata, vt[i].wdata);
                check("st_wstrb",   {28'd0, cap_wstrb}, {28'd0, vt[i].wen});
                check("st_ids",     {24'd0, cap_awid, cap_wid}, 32'h11);
                check("st_fixed",   {20'd0, cap_awlen, 1'b0, cap_awsize, 2'b0, cap_awburst}, {20'd0, 4'd0, 1'b0, 3'b010, 2'b0, 2'b01});
                check("st_wlast",   {31'd0, cap_wlast}, 1);
            end else begin
                check("rd_ar_count", ar_n - ar0, 1);
                check("rd_araddr",  ar_hist_addr[ar0 % 64], vt[i].addr);
                check("rd_arid",    {28'd0, ar_hist_id[ar0 % 64]}, vt[i].is_data ? 32'd1 : 32'd0);
                check("rd_fixed",   {20'd0, cap_arlen, 1'b0, cap_arsize, 2'b0, cap_arburst}, {20'd0, 4'd0, 1'b0, 3'b010, 2'b0, 2'b01});
            end
        end

        // contention: data and fetch raised together
        ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
        rd_word_d = 32'hDEAD_BEEF; rd_word_i = 32'h0800_0000;
        ar0 = ar_n; t0 = cyc;
        issue(1, 4'h0, 32'h1FC0_0010, 32'h0, 32'hDEAD_BEEF, 3);
        issue(0, 4'h0, 32'hBFC0_0100, 32'h0, 32'h0800_0000, 7);
        run_until_empty(100);
        check("cont_ar_count", ar_n - ar0, 2);
        check("cont_first_id",  {28'd0, ar_hist_id[ar0 % 64]}, 1);
        check("cont_second_id", {28'd0, ar_hist_id[(ar0 + 1) % 64]}, 0);
        check("cont_second_addr", ar_hist_addr[(ar0 + 1) % 64], 32'hBFC0_0100);
        check("cont_fetch_after_done", {31'd0, ar_hist_cyc[(ar0 + 1) % 64] > t0 + 3}, 1);

        // AR stall: arready low for 5 cycles
        ar_wait = 5; rd_word_i = 32'h0000_0111;
        issue(0, 4'h0, 32'h0000_0100, 32'h0, 32'h0000_0111, 8);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("stall_hold", {31'd0, cpu_stall}, 1);
            if (k >= 1 && k <= 6) begin
                check("stall_arvalid", {31'd0, axi.arvalid}, 1);
                check("stall_araddr", axi.araddr, 32'h0000_0100);
            end
        end
        run_until_empty(100);
        check("stall_cleared", {31'd0, cpu_stall}, 0);
        ar_wait = 0;

        // async reset while waiting in the fetch R phase
        r_wait = 10; rd_word_i = 32'h0000_0222;
        inst_addr = 32'h0000_0200; inst_req = 1'b1;
        @(posedge clk); @(posedge clk); #2;
        check("pre_rst_rready", {31'd0, axi.rready}, 1);
        resetn = 1'b0; #1;
        check("mid_rst_arvalid", {31'd0, axi.arvalid}, 0);
        check("mid_rst_rready",  {31'd0, axi.rready},  0);
        check("mid_rst_wr_valid", {30'd0, axi.awvalid, axi.wvalid}, 0);
        check("mid_rst_done",    {30'd0, inst_done, data_done}, 0);
        check("mid_rst_rdata",   inst_rdata | data_rdata, 0);
        inst_req = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk) resetn = 1'b1;
        @(posedge clk); #1;
        r_wait = 0; ar0 = ar_n;
        issue(0, 4'h0, 32'h0000_0200, 32'h0, 32'h0000_0222, 3);
        run_until_empty(100);
        check("post_rst_ar_count", ar_n - ar0, 1);
        check("post_rst_araddr", ar_hist_addr[ar0 % 64], 32'h0000_0200);

`ifdef SRAM_AXI_BRIDGE_IBUF_EN
        rd_word_i = 32'h3C08_0001;
        ar0 = ar_n;
        issue(0, 4'h0, 32'hBFC0_0000, 32'h0, 32'h3C08_0001, 3);
        run_until_empty(100);
        check("ibuf_miss_ar", ar_n - ar0, 1);
        ar0 = ar_n; av0 = av_cyc;
        issue(0, 4'h0, 32'hBFC0_0000, 32'h0, 32'h3C08_0001, 1);
        run_until_empty(100);
        check("ibuf_hit_no_ar", ar_n - ar0, 0);
        check("ibuf_hit_no_arvalid", av_cyc - av0, 0);
        issue(1, 4'hF, 32'h0000_0300, 32'h0000_0001, 32'h0, 3);
        run_until_empty(100);
        ar0 = ar_n;
        issue(0, 4'h0, 32'hBFC0_0000, 32'h0, 32'h3C08_0001, 3);
        run_until_empty(100);
        check("ibuf_inval_ar", ar_n - ar0, 1);
`endif

        check("handshake_stability", stab_viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
